// File: rtl/frag_pkg.sv
// frag_pkg: shared widths, FSM state encoding and colour triple for the fragment shading stage
package frag_pkg;
    localparam int FRAG_NW = 18;
    localparam int FRAG_AW = 19;
    localparam int FRAG_CW = 4;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_R,
        ST_DIV_G,
        ST_DIV_B,
        ST_OUT
    } frag_state_t;
    typedef struct packed {
        logic [FRAG_CW-1:0] r;
        logic [FRAG_CW-1:0] g;
        logic [FRAG_CW-1:0] b;
    } frag_rgb_t;
endpackage

// File: rtl/divider_16x.sv
// divider_16x: combinational o_quo = min(2^CW-1, floor(2^CW * i_num / i_den))
// Ports: i_num numerator, i_den denominator, o_quo saturated quotient.
// A zero denominator yields all-ones; the caller handles degenerate triangles.
module divider_16x
    import frag_pkg::*;
#(
    parameter int NW = FRAG_NW,
    parameter int AW = FRAG_AW,
    parameter int CW = FRAG_CW
) (
    input  logic [NW-1:0] i_num,
    input  logic [AW-1:0] i_den,
    output logic [CW-1:0] o_quo
);
    logic [AW:0]   w_rem;
    logic [CW-1:0] w_q;
    // Once i_num < i_den the quotient fits in CW bits, so CW restoring
    // steps suffice; everything else saturates.
    always_comb begin
        w_rem = {{(AW + 1 - NW){1'b0}}, i_num};
        w_q   = '0;
        for (int i = CW - 1; i >= 0; i--) begin
            w_rem = w_rem << 1;
            if (w_rem >= {1'b0, i_den}) begin
                w_q[i] = 1'b1;
                w_rem  = w_rem - {1'b0, i_den};
            end
        end
        o_quo = ({{(AW - NW){1'b0}}, i_num} >= i_den) ? '1 : w_q;
    end
endmodule

// File: rtl/frag_shade_seq.sv
// frag_shade_seq: shades one fragment through a single shared divider, one channel per cycle
// Ports: clk/rst_n (async active-low); i_in_valid/o_in_ready input handshake with
// i_visible, i_ua/i_va/i_wa numerators and i_a area; o_out_valid/i_out_ready
// output handshake carrying o_r/o_g/o_b.
module frag_shade_seq
    import frag_pkg::*;
#(
    parameter int AW = FRAG_AW,
    parameter int NW = FRAG_NW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic               i_visible,
    input  logic [NW-1:0]      i_ua,
    input  logic [NW-1:0]      i_va,
    input  logic [NW-1:0]      i_wa,
    input  logic [AW-1:0]      i_a,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [FRAG_CW-1:0] o_r,
    output logic [FRAG_CW-1:0] o_g,
    output logic [FRAG_CW-1:0] o_b
);
    frag_state_t        r_state;
    logic [NW-1:0]      r_ua;
    logic [NW-1:0]      r_va;
    logic [NW-1:0]      r_wa;
    logic [AW-1:0]      r_a;
    logic               r_vis;
    frag_rgb_t          r_rgb;
    logic               r_out_valid;
    logic [NW-1:0]      w_num;
    logic [FRAG_CW-1:0] w_quo;
    logic [FRAG_CW-1:0] w_chan;
    logic               w_accept;
    logic               w_go;

    assign o_in_ready  = (r_state == ST_IDLE) || (r_state == ST_OUT && i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_go        = i_visible && (i_a != '0);
    assign w_num       = (r_state == ST_DIV_R) ? r_ua : (r_state == ST_DIV_G) ? r_va : r_wa;
    // Invisible fragments never reach the divide states; the gate keeps a
    // stray entry from producing colour for one.
    assign w_chan      = r_vis ? w_quo : '0;
    assign o_out_valid = r_out_valid;
    assign o_r         = r_rgb.r;
    assign o_g         = r_rgb.g;
    assign o_b         = r_rgb.b;

    divider_16x #(.NW(NW), .AW(AW), .CW(FRAG_CW)) u_div (
        .i_num (w_num),
        .i_den (r_a),
        .o_quo (w_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ua        <= '0;
            r_va        <= '0;
            r_wa        <= '0;
            r_a         <= '0;
            r_vis       <= 1'b0;
            r_rgb       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OUT: begin
                    if (w_accept) begin
                        r_ua  <= i_ua;
                        r_va  <= i_va;
                        r_wa  <= i_wa;
                        r_a   <= i_a;
                        r_vis <= i_visible;
                        if (w_go) begin
                            r_state     <= ST_DIV_R;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_OUT;
                            r_rgb       <= '0;
                            r_out_valid <= 1'b1;
                        end
                    end else if (r_state == ST_OUT && i_out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_DIV_R: begin
                    r_rgb.r <= w_chan;
                    r_state <= ST_DIV_G;
                end
                ST_DIV_G: begin
                    r_rgb.g <= w_chan;
                    r_state <= ST_DIV_B;
                end
                ST_DIV_B: begin
                    r_rgb.b     <= w_chan;
                    r_state     <= ST_OUT;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frag_shade_seq.sv
// tb_frag_shade_seq: scenario tasks checking frag_shade_seq against an arithmetic shading model
module tb_frag_shade_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        i_visible = 1'b0;
    logic [17:0] i_ua = '0;
    logic [17:0] i_va = '0;
    logic [17:0] i_wa = '0;
    logic [18:0] i_a = '0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b1;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    frag_shade_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_visible   (i_visible),
        .i_ua        (i_ua),
        .i_va        (i_va),
        .i_wa        (i_wa),
        .i_a         (i_a),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_r         (o_r),
        .o_g         (o_g),
        .o_b         (o_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] shade(input longint n, input longint a, input bit vis);
        longint q;
        if (!vis || a == 0) return 4'd0;
        q = (16 * n) / a;
        return (q > 15) ? 4'd15 : 4'(q);
    endfunction

    function automatic logic [11:0] ref_rgb(input bit vis, input longint u, input longint v,
                                            input longint w, input longint a);
        return {shade(u, a, vis), shade(v, a, vis), shade(w, a, vis)};
    endfunction

    task automatic accept(input bit vis, input logic [17:0] u, input logic [17:0] v,
                          input logic [17:0] w, input logic [18:0] a);
        int n = 0;
        @(negedge clk);
        i_visible = vis; i_ua = u; i_va = v; i_wa = w; i_a = a;
        i_in_valid = 1'b1;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!o_in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", o_in_ready);
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        i_ua = 18'($urandom); i_va = 18'($urandom); i_wa = 18'($urandom);
        i_a = 19'($urandom); i_visible = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_out_valid && lat < 50);
    endtask

    task automatic check_frag(input string name, input bit vis, input logic [17:0] u,
                              input logic [17:0] v, input logic [17:0] w, input logic [18:0] a);
        int lat;
        int exp_lat;
        logic [11:0] exp;
        exp     = ref_rgb(vis, u, v, w, a);
        exp_lat = (vis && a != 0) ? 4 : 1;
        accept(vis, u, v, w, a);
        wait_out(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if ({o_r, o_g, o_b} !== exp) begin
            errors++;
            $display("FAIL %s_rgb got %h required %h", name, {o_r, o_g, o_b}, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_in_ready, o_out_valid, o_r, o_g, o_b} !== {1'b1, 1'b0, 12'h000}) begin
            errors++;
            $display("FAIL reset got rdy=%0b vld=%0b rgb=%h required rdy=1 vld=0 rgb=000",
                     o_in_ready, o_out_valid, {o_r, o_g, o_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle got vld=%0b rdy=%0b required vld=0 rdy=1",
                     name, o_out_valid, o_in_ready);
        end
    endtask

    task automatic test_basic();
        i_out_ready = 1'b1;
        check_frag("basic", 1'b1, 18'd150, 18'd75, 18'd75, 19'd300);
        check_idle("basic");
    endtask

    task automatic test_invisible();
        check_frag("invisible", 1'b0, 18'd100, 18'd100, 18'd100, 19'd100);
        check_frag("degenerate", 1'b1, 18'd100, 18'd100, 18'd100, 19'd0);
        check_idle("degenerate");
    endtask

    task automatic test_saturation();
        check_frag("saturation", 1'b1, 18'd10, 18'd9, 18'd0, 19'd10);
        check_frag("max_operands", 1'b1, 18'h3FFFF, 18'h1FFFF, 18'd1, 19'h7FFFF);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] held;
        i_out_ready = 1'b0;
        accept(1'b1, 18'd200, 18'd50, 18'd120, 19'd400);
        wait_out(lat);
        held = {o_r, o_g, o_b};
        checks++;
        if (held !== ref_rgb(1'b1, 200, 50, 120, 400)) begin
            errors++;
            $display("FAIL bp_rgb got %h required %h", held, ref_rgb(1'b1, 200, 50, 120, 400));
        end
        i_in_valid = 1'b1; i_visible = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({o_out_valid, o_in_ready, o_r, o_g, o_b} !== {1'b1, 1'b0, held}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got vld=%0b rdy=%0b rgb=%h required vld=1 rdy=0 rgb=%h",
                         k, o_out_valid, o_in_ready, {o_r, o_g, o_b}, held);
            end
        end
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        @(posedge clk);
        check_idle("bp_release");
        @(negedge clk);
        checks++;
        if (o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_handshake got vld=%0b required 0", o_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] fu[3];
        logic [17:0] fv[3];
        logic [17:0] fw[3];
        logic [18:0] fa[3];
        int acc[3];
        int ni = 0;
        int no = 0;
        logic rdy;
        logic [11:0] exp;
        for (int k = 0; k < 3; k++) begin
            fa[k] = 19'($urandom_range(1000, 300000));
            fu[k] = 18'($urandom_range(0, 262143));
            fv[k] = 18'($urandom_range(0, 2000));
            fw[k] = 18'($urandom_range(0, int'(fa[k]) > 262143 ? 262143 : int'(fa[k])));
        end
        i_out_ready = 1'b1;
        for (int k = 0; k < 40 && no < 3; k++) begin
            @(negedge clk);
            if (o_out_valid) begin
                exp = ref_rgb(1'b1, fu[no], fv[no], fw[no], fa[no]);
                checks++;
                if ({o_r, o_g, o_b} !== exp) begin
                    errors++;
                    $display("FAIL b2b_rgb frag %0d got %h required %h", no, {o_r, o_g, o_b}, exp);
                end
                no++;
            end
            if (ni < 3) begin
                i_visible = 1'b1; i_ua = fu[ni]; i_va = fv[ni]; i_wa = fw[ni]; i_a = fa[ni];
                i_in_valid = 1'b1;
            end else begin
                i_in_valid = 1'b0;
            end
            rdy = o_in_ready;
            @(posedge clk);
            if (rdy && i_in_valid) begin
                acc[ni] = cyc;
                ni++;
            end
        end
        #1;
        i_in_valid = 1'b0;
        checks++;
        if (no !== 3 || ni !== 3) begin
            errors++;
            $display("FAIL b2b_count got accepts=%0d outputs=%0d required 3 and 3", ni, no);
        end else begin
            checks++;
            if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
                errors++;
                $display("FAIL b2b_spacing got %0d,%0d required 4,4",
                         acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        i_out_ready = 1'b1;
        accept(1'b1, 18'd150, 18'd75, 18'd75, 19'd300);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_in_ready, o_out_valid, o_r, o_g, o_b} !== {1'b1, 1'b0, 12'h000}) begin
            errors++;
            $display("FAIL reset_mid got rdy=%0b vld=%0b rgb=%h required rdy=1 vld=0 rgb=000",
                     o_in_ready, o_out_valid, {o_r, o_g, o_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_frag("after_reset", 1'b1, 18'd90, 18'd30, 18'd299, 19'd300);
    endtask

    task automatic test_random();
        logic [18:0] a;
        bit vis;
        for (int k = 0; k < 16; k++) begin
            vis = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 5) == 0) ? 19'd0 : 19'($urandom_range(1, 524287));
            check_frag("random", vis, 18'($urandom), 18'($urandom_range(0, 4096)),
                       18'($urandom), a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invisible();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
